bitstream_reader: RTL and testbench

BITSTREAM_READER -- requirements
Module: bitstream_reader

---
 rtl/mpeg_pkg.sv | 24 ++
 rtl/bitstream_reader.sv | 98 +++++++++
 tb/tb_bitstream_reader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mpeg_pkg.sv
// Shared MPEG bitstream constants and helpers used by bitstream_reader,
// flushbuffer and get_motion_code.
package mpeg_pkg;

  localparam int unsigned BUF_BITS  = 64;
  localparam int unsigned MAX_FLUSH = 32;
  localparam int unsigned BYTE_BITS = 8;

  localparam int unsigned CNT_W   = 7;
  localparam int unsigned POS_W   = 32;
  localparam int unsigned FLUSH_W = 6;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_FLUSH,
    OP_ALIGN
  } shift_op_e;

  // Bits left to reach the next byte boundary: (8 - pos) mod 8.
  function automatic logic [2:0] align_skip(input logic [2:0] pos_lsb);
    return 3'd0 - pos_lsb;
  endfunction

endpackage

// File: rtl/bitstream_reader.sv
// MSB-first bit window over a byte stream: shows 32 bits, consumes 1..32 bits
// per flush, byte-aligns on request and appends bytes in the same cycle.
module bitstream_reader
  import mpeg_pkg::*;
#(
  parameter int unsigned BUF_BITS = mpeg_pkg::BUF_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic [31:0] show_bits,
  output logic        show_valid,
  input  logic        flush_req,
  input  logic [5:0]  flush_n,
  output logic        flush_ack,
  input  logic        align_req,
  output logic [6:0]  bit_count,
  output logic [31:0] bit_pos,
  output logic        err
);

  logic [BUF_BITS-1:0] window_q, window_d;
  logic [CNT_W-1:0]    bit_count_q, bit_count_d;
  logic [POS_W-1:0]    bit_pos_q, bit_pos_d;
  logic                err_q, err_d;

  shift_op_e           op;
  logic [FLUSH_W-1:0]  shamt;
  logic [FLUSH_W-1:0]  align_k;
  logic                flush_legal;
  logic                flush_ok;
  logic                accept;
  logic [BUF_BITS-1:0] shifted;
  logic [CNT_W-1:0]    count_s;

  assign in_ready   = (bit_count_q <= CNT_W'(BUF_BITS - BYTE_BITS));
  assign accept     = in_valid && in_ready;
  assign show_bits  = window_q[BUF_BITS-1 -: 32];
  assign show_valid = (bit_count_q >= CNT_W'(MAX_FLUSH));
  assign bit_count  = bit_count_q;
  assign bit_pos    = bit_pos_q;
  assign err        = err_q;
  assign flush_ack  = flush_ok;

  always_comb begin
    flush_legal = (flush_n != '0) && (flush_n <= FLUSH_W'(MAX_FLUSH));
    flush_ok    = flush_req && flush_legal &&
                  (CNT_W'(flush_n) <= bit_count_q) && !align_req;
    align_k     = {3'b000, align_skip(bit_pos_q[2:0])};

    op = OP_NONE;
    if (align_req) begin
      if (CNT_W'(align_k) <= bit_count_q) op = OP_ALIGN;
    end else if (flush_ok) begin
      op = OP_FLUSH;
    end

    case (op)
      OP_FLUSH: shamt = flush_n;
      OP_ALIGN: shamt = align_k;
      default:  shamt = '0;
    endcase

    // Consume first, then append the byte just below the surviving bits.
    shifted = window_q << shamt;
    count_s = bit_count_q - CNT_W'(shamt);

    window_d    = shifted;
    bit_count_d = count_s;
    if (accept) begin
      window_d    = shifted | ({in_byte, {(BUF_BITS-BYTE_BITS){1'b0}}} >> count_s);
      bit_count_d = count_s + CNT_W'(BYTE_BITS);
    end

    bit_pos_d = bit_pos_q + POS_W'(shamt);
    err_d     = err_q | (flush_req && !flush_legal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q    <= '0;
      bit_count_q <= '0;
      bit_pos_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      window_q    <= window_d;
      bit_count_q <= bit_count_d;
      bit_pos_q   <= bit_pos_d;
      err_q       <= err_d;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    bit_count_q <= CNT_W'(BUF_BITS));

endmodule

// File: tb/tb_bitstream_reader.sv
// Directed bench for bitstream_reader with hand-computed expectations.
module tb_bitstream_reader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [31:0] show_bits;
  logic        show_valid;
  logic        flush_req;
  logic [5:0]  flush_n;
  logic        flush_ack;
  logic        align_req;
  logic [6:0]  bit_count;
  logic [31:0] bit_pos;
  logic        err;

  int unsigned n_checks;
  int unsigned n_pass;

  bitstream_reader #(.BUF_BITS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .show_bits  (show_bits),
    .show_valid (show_valid),
    .flush_req  (flush_req),
    .flush_n    (flush_n),
    .flush_ack  (flush_ack),
    .align_req  (align_req),
    .bit_count  (bit_count),
    .bit_pos    (bit_pos),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [5:0] n, input logic exp_ack);
    flush_req = 1'b1;
    flush_n   = n;
    #1;
    check($sformatf("flush_ack n=%0d", n), 64'(flush_ack), 64'(exp_ack));
    @(posedge clk); #1;
    flush_req = 1'b0;
  endtask

  task automatic do_align();
    align_req = 1'b1;
    @(posedge clk); #1;
    align_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; in_valid = 1'b0; in_byte = '0;
    flush_req = 1'b0; flush_n = '0; align_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst show_bits", 64'(show_bits), 64'h0);
    check("rst bit_count", 64'(bit_count), 64'd0);
    check("rst bit_pos", 64'(bit_pos), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst show_valid", 64'(show_valid), 64'd0);
    check("rst err", 64'(err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    push(8'h00); push(8'h68); push(8'h78); push(8'h30);
    check("fill show_bits", 64'(show_bits), 64'h00687830);
    check("fill show_valid", 64'(show_valid), 64'd1);
    check("fill bit_count", 64'(bit_count), 64'd32);

    do_flush(6'd12, 1'b1);
    check("f12 show_bits", 64'(show_bits), 64'h87830000);
    check("f12 bit_count", 64'(bit_count), 64'd20);
    check("f12 bit_pos", 64'(bit_pos), 64'd12);

    do_flush(6'd1, 1'b1);
    check("f1 bit_pos", 64'(bit_pos), 64'd13);
    check("f1 show_bits", 64'(show_bits), 64'h0F060000);
    do_align();
    check("align bit_pos", 64'(bit_pos), 64'd16);
    check("align bit_count", 64'(bit_count), 64'd16);
    check("align show_bits", 64'(show_bits), 64'h78300000);
    do_align();
    check("align2 bit_pos", 64'(bit_pos), 64'd16);
    check("align2 bit_count", 64'(bit_count), 64'd16);

    check("err before", 64'(err), 64'd0);
    do_flush(6'd0, 1'b0);
    check("f0 err", 64'(err), 64'd1);
    check("f0 bit_count", 64'(bit_count), 64'd16);
    do_flush(6'd40, 1'b0);
    check("f40 bit_count", 64'(bit_count), 64'd16);
    check("f40 err", 64'(err), 64'd1);

    // Legal flush of 20 with 16 bits buffered stalls until a byte arrives.
    flush_req = 1'b1; flush_n = 6'd20;
    #1;
    check("stall ack", 64'(flush_ack), 64'd0);
    @(posedge clk); #1;
    check("stall bit_count", 64'(bit_count), 64'd16);
    in_valid = 1'b1; in_byte = 8'hAB;
    #1;
    check("stall ack w/ byte", 64'(flush_ack), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall byte count", 64'(bit_count), 64'd24);
    check("stall show_bits", 64'(show_bits), 64'h7830AB00);
    check("stall released ack", 64'(flush_ack), 64'd1);
    @(posedge clk); #1;
    flush_req = 1'b0;
    check("f20 bit_count", 64'(bit_count), 64'd4);
    check("f20 bit_pos", 64'(bit_pos), 64'd36);
    check("f20 show_bits", 64'(show_bits), 64'hB0000000);
    check("err sticky", 64'(err), 64'd1);

    do_align();
    check("align4 bit_count", 64'(bit_count), 64'd0);
    check("align4 bit_pos", 64'(bit_pos), 64'd40);

    for (int unsigned i = 1; i <= 8; i++) push(8'(i * 8'h11));
    check("full bit_count", 64'(bit_count), 64'd64);
    check("full in_ready", 64'(in_ready), 64'd0);
    check("full show_bits", 64'(show_bits), 64'h11223344);

    flush_req = 1'b1; flush_n = 6'd8;
    in_valid = 1'b1; in_byte = 8'hA5;
    #1;
    check("full ack", 64'(flush_ack), 64'd1);
    check("full ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    check("after f8 ready", 64'(in_ready), 64'd1);
    check("after f8 count", 64'(bit_count), 64'd56);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("refill count", 64'(bit_count), 64'd64);
    check("refill show_bits", 64'(show_bits), 64'h22334455);
    check("refill bit_pos", 64'(bit_pos), 64'd48);
    do_flush(6'd32, 1'b1);
    check("f32 show_bits", 64'(show_bits), 64'h667788A5);
    check("f32 bit_count", 64'(bit_count), 64'd32);
    check("f32 bit_pos", 64'(bit_pos), 64'd80);

    push(8'h5A);
    check("pre-rst count", 64'(bit_count), 64'd40);
    in_valid = 1'b1; in_byte = 8'hC3;
    #2;
    rst = 1'b1;
    #1;
    check("arst bit_count", 64'(bit_count), 64'd0);
    check("arst show_bits", 64'(show_bits), 64'h0);
    check("arst bit_pos", 64'(bit_pos), 64'd0);
    check("arst err", 64'(err), 64'd0);
    check("arst in_ready", 64'(in_ready), 64'd1);
    check("arst show_valid", 64'(show_valid), 64'd0);
    @(posedge clk); #1;
    check("rst held count", 64'(bit_count), 64'd0);
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst count", 64'(bit_count), 64'd0);
    check("post-rst show_bits", 64'(show_bits), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1);
  end

endmodule
